// File: rtl/alu_sequencer_if.sv
// ============================================================================
// Module      : alu_sequencer_if
// Description : Command, ALU-drive and result bundle for alu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface alu_sequencer_if #(
    parameter int COUNT_W = 8
);
    // Command channel
    logic               CMD_VALID;
    logic               CMD_READY;
    logic [3:0]         CMD_A;
    logic [3:0]         CMD_B;
    logic [1:0]         CMD_OP;
    logic               CMD_CHAIN;

    // ALU drive / return
    logic [3:0]         ALU_A;
    logic [3:0]         ALU_B;
    logic               ALU_CTRL0;
    logic               ALU_CTRL1;
    logic [3:0]         ALU_C;
    logic               ALU_OVF;

    // Result channel and status
    logic               RES_VALID;
    logic               RES_READY;
    logic [3:0]         RES_C;
    logic               RES_OVF;
    logic               OVF_STICKY;
    logic               CLR_STICKY;
    logic [COUNT_W-1:0] OP_COUNT;

    // Sequencer side
    modport slave (
        input  CMD_VALID, CMD_A, CMD_B, CMD_OP, CMD_CHAIN,
        output CMD_READY,
        output ALU_A, ALU_B, ALU_CTRL0, ALU_CTRL1,
        input  ALU_C, ALU_OVF,
        output RES_VALID, RES_C, RES_OVF, OVF_STICKY, OP_COUNT,
        input  RES_READY, CLR_STICKY
    );

    // Command source / ALU / result sink side
    modport master (
        output CMD_VALID, CMD_A, CMD_B, CMD_OP, CMD_CHAIN,
        input  CMD_READY,
        input  ALU_A, ALU_B, ALU_CTRL0, ALU_CTRL1,
        output ALU_C, ALU_OVF,
        input  RES_VALID, RES_C, RES_OVF, OVF_STICKY, OP_COUNT,
        output RES_READY, CLR_STICKY
    );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Valid/ready front-end that drives a 4-bit ALU, waits one
//               settle cycle, captures C/OVF and presents it downstream.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_sequencer #(
    parameter int COUNT_W = 8
) (
`ifdef USE_POWER_PINS
    inout  wire         vccd1,
    inout  wire         vssd1,
`endif
    input  wire logic   wb_clk_i,
    input  wire logic   wb_rst_i,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] c_count_one = COUNT_W'(1);

    state_t             r_state;
    logic               r_cmd_ready;
    logic [3:0]         r_alu_a;
    logic [3:0]         r_alu_b;
    logic [1:0]         r_ctrl;
    logic [3:0]         r_res_c;
    logic               r_res_ovf;
    logic               r_res_valid;
    logic               r_acc_valid;
    logic               r_sticky;
    logic [COUNT_W-1:0] r_count;

    logic [3:0]         w_next_a;

    // RES_C doubles as the chain accumulator once any result has been captured
    assign w_next_a = (bus.CMD_CHAIN && r_acc_valid) ? r_res_c : bus.CMD_A;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_ctrl      <= 2'd0;
            r_res_c     <= 4'd0;
            r_res_ovf   <= 1'b0;
            r_res_valid <= 1'b0;
            r_acc_valid <= 1'b0;
            r_sticky    <= 1'b0;
            r_count     <= '0;
        end else begin
            // A capture with OVF=1 later in this block overrides the clear
            if (bus.CLR_STICKY) begin
                r_sticky <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.CMD_VALID) begin
                        r_alu_a     <= w_next_a;
                        r_alu_b     <= bus.CMD_B;
                        r_ctrl      <= bus.CMD_OP;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    r_res_c     <= bus.ALU_C;
                    r_res_ovf   <= bus.ALU_OVF;
                    r_res_valid <= 1'b1;
                    r_acc_valid <= 1'b1;
                    r_count     <= r_count + c_count_one;
                    if (bus.ALU_OVF) begin
                        r_sticky <= 1'b1;
                    end
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (bus.RES_READY) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_res_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.CMD_READY  = r_cmd_ready;
    assign bus.ALU_A      = r_alu_a;
    assign bus.ALU_B      = r_alu_b;
    assign bus.ALU_CTRL0  = r_ctrl[0];
    assign bus.ALU_CTRL1  = r_ctrl[1];
    assign bus.RES_VALID  = r_res_valid;
    assign bus.RES_C      = r_res_c;
    assign bus.RES_OVF    = r_res_ovf;
    assign bus.OVF_STICKY = r_sticky;
    assign bus.OP_COUNT   = r_count;

endmodule

`default_nettype wire
